// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory bus and decode-side stream bundle for instr_fetch_unit
interface instr_fetch_unit_if #(
    parameter int DWIDTH = 32
);
    // Instruction memory read channel: req/gnt handshake, rvalid response
    logic              imem_req;
    logic [DWIDTH-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [DWIDTH-1:0] imem_rdata;

    // Fetched instruction stream towards decode: valid/ready handshake
    logic              instr_valid;
    logic [DWIDTH-1:0] instr;
    logic [DWIDTH-1:0] instr_pc;
    logic              instr_ready;

    // Fetch unit side
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata,
        output instr_valid,
        output instr,
        output instr_pc,
        input  instr_ready
    );

    // Memory and decode side
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata,
        input  instr_valid,
        input  instr,
        input  instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch front end with 2-entry PC-tagged buffer; IFU_MISALIGN_CHECK_EN adds misaligned-PC fault
module instr_fetch_unit #(
    parameter int DWIDTH     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DWIDTH-1:0] pc_value,
    input  logic              flush,
    output logic              pc_en,
    output logic              fetch_fault,
    instr_fetch_unit_if.master bus
);

    // Buffer is fixed at two entries: 1-bit pointers, 2-bit occupancy count
    localparam int CW = 2;
    localparam int PW = 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

`ifdef IFU_MISALIGN_CHECK_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DROP  = 3'd3,
        FAULT = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DROP  = 3'd3
    } state_t;
`endif

    state_t            state;
    state_t            state_nxt;

    logic [CW-1:0]     count;
    logic [CW-1:0]     count_nxt;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [DWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] mem_instr [FIFO_DEPTH];
    logic [DWIDTH-1:0] mem_pc    [FIFO_DEPTH];

    logic              misaligned;
    logic              outstanding;
    logic              fire;
    logic              resp;
    logic              push;
    logic              pop;
    logic              room_nxt;

`ifdef IFU_MISALIGN_CHECK_EN
    assign misaligned = (pc_value[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // A request is in flight from grant until its response, whether live or flushed
    assign outstanding = (state == WAIT) || (state == DROP);

    // Request is Moore from REQ; a misaligned PC never reaches the bus
    assign bus.imem_req  = (state == REQ) && !misaligned;
    assign bus.imem_addr = pc_value;

    assign fire  = bus.imem_req & bus.imem_gnt;
    assign pc_en = fire | flush;

    // Responses only count while something is outstanding; stray rvalid is ignored
    assign resp = bus.imem_rvalid & outstanding;
    assign push = resp & (state == WAIT) & ~flush;
    assign pop  = bus.instr_valid & bus.instr_ready & ~flush;

    // Buffer head drives decode directly
    assign bus.instr_valid = (count != '0);
    assign bus.instr       = mem_instr[rd_ptr];
    assign bus.instr_pc    = mem_pc[rd_ptr];

`ifdef IFU_MISALIGN_CHECK_EN
    assign fetch_fault = (state == FAULT);
`else
    assign fetch_fault = 1'b0;
`endif

    // Occupancy after this edge; flush empties the buffer and overrides any pop
    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else if (push && !pop) begin
            count_nxt = count + 1'b1;
        end else if (pop && !push) begin
            count_nxt = count - 1'b1;
        end
    end

    // A new request may only start when its response is guaranteed a slot
    assign room_nxt = (count_nxt < DEPTH_C);

    // Next-state logic; flush is evaluated first in every state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (flush) begin
                    state_nxt = IDLE;
`ifdef IFU_MISALIGN_CHECK_EN
                end else if (misaligned) begin
                    state_nxt = FAULT;
`endif
                end else if (room_nxt) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (flush) begin
                    state_nxt = fire ? DROP : IDLE;
`ifdef IFU_MISALIGN_CHECK_EN
                end else if (misaligned) begin
                    state_nxt = FAULT;
`endif
                end else if (fire) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (flush) begin
                    state_nxt = bus.imem_rvalid ? IDLE : DROP;
                end else if (bus.imem_rvalid) begin
                    state_nxt = room_nxt ? REQ : IDLE;
                end
            end
            DROP: begin
                if (bus.imem_rvalid) begin
                    state_nxt = IDLE;
                end
            end
`ifdef IFU_MISALIGN_CHECK_EN
            FAULT: begin
                if (flush) begin
                    state_nxt = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // State register and address of the request currently in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            addr_q <= '0;
        end else begin
            state <= state_nxt;
            if (fire) begin
                addr_q <= pc_value;
            end
        end
    end

    // Buffer pointers and occupancy; pointers wrap naturally at two entries
    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            count <= count_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Buffer storage, cleared on reset so the head reads zero when empty
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_instr[i] <= '0;
                mem_pc[i]    <= '0;
            end
        end else if (push) begin
            mem_instr[wr_ptr] <= bus.imem_rdata;
            mem_pc[wr_ptr]    <= addr_q;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_value;
    logic        flush;
    logic        pc_en;
    logic        fetch_fault;

    instr_fetch_unit_if #(.DWIDTH(32)) bus ();

    instr_fetch_unit #(
        .DWIDTH     (32),
        .FIFO_DEPTH (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_value    (pc_value),
        .flush       (flush),
        .pc_en       (pc_en),
        .fetch_fault (fetch_fault),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
    } ent_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;

    // Environment knobs
    bit          gnt_en, resp_en, ready_en, flush_req, force_en;
    logic [31:0] flush_target, force_data;

    // Reference model: buffered fetches, the one request in flight, pop log
    ent_t        q[$];
    bit          outst, live;
    logic [31:0] outst_addr;
    logic [31:0] pop_pc[$];
    logic [31:0] pop_ins[$];
    int          pop_cyc[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive at negedge, compare, then advance model and PC controller
    task automatic cycle();
        bit          fire, pcen, popped, pushed, fl, rv;
        logic [31:0] rd, head_pc, head_ins;
        @(negedge clk);
        bus.imem_gnt    = gnt_en & bus.imem_req;
        rv              = outst & resp_en;
        rd              = force_en ? force_data : mem_word(outst_addr);
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rv ? rd : 32'h0;
        bus.instr_ready = ready_en;
        flush           = flush_req;
        fl              = flush_req;
        #1;
        if (!reset) begin
            check("instr_valid", bus.instr_valid, (q.size() != 0));
            if (q.size() != 0) begin
                check("instr", bus.instr, q[0].ins);
                check("instr_pc", bus.instr_pc, q[0].pc);
            end
            check("pc_en", pc_en, (bus.imem_req & bus.imem_gnt) | fl);
            if (bus.imem_req) begin
                check("req_addr", bus.imem_addr, pc_value);
                check("req_while_outstanding", outst, 0);
                check("req_without_room", (q.size() < 2), 1);
            end
`ifndef IFU_MISALIGN_CHECK_EN
            check("fetch_fault", fetch_fault, 0);
`endif
        end
        fire     = bus.imem_req & bus.imem_gnt;
        pcen     = pc_en;
        popped   = bus.instr_valid & ready_en & !fl;
        pushed   = rv & live & !fl;
        head_pc  = bus.instr_pc;
        head_ins = bus.instr;
        @(posedge clk);
        #1;
        if (reset) begin
            q.delete();
            outst    = 0;
            live     = 0;
            pc_value = 32'h0;
        end else begin
            if (fl) begin
                q.delete();
            end else begin
                if (popped) begin
                    pop_pc.push_back(head_pc);
                    pop_ins.push_back(head_ins);
                    pop_cyc.push_back(cyc);
                    void'(q.pop_front());
                end
                if (pushed) q.push_back('{ins: rd, pc: outst_addr});
            end
            if (rv) outst = 0;
            if (fl) live = 0;
            if (fire) begin
                outst      = 1;
                outst_addr = pc_value;
                live       = !fl;
            end
            if (pcen) pc_value = fl ? flush_target : pc_value + 32'd4;
        end
        flush_req = 0;
        cyc++;
        #1;
    endtask

    initial begin
        reset           = 1'b1;
        pc_value        = 32'h0;
        flush           = 1'b0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.instr_ready = 1'b0;
        gnt_en = 0; resp_en = 0; ready_en = 0; flush_req = 0; force_en = 0;
        flush_target = 32'h0; force_data = 32'h0;
        outst = 0; live = 0; outst_addr = 32'h0;

        // Reset held two cycles
        repeat (2) @(posedge clk);
        #1;
        check("rst_imem_req", bus.imem_req, 0);
        check("rst_pc_en", pc_en, 0);
        check("rst_instr_valid", bus.instr_valid, 0);
        check("rst_instr", bus.instr, 32'h0);
        check("rst_instr_pc", bus.instr_pc, 32'h0);
        check("rst_fetch_fault", fetch_fault, 0);
        reset = 1'b0;

        cycle();
        check("first_req", bus.imem_req, 1);
        check("first_addr", bus.imem_addr, 32'h0);

        // Backpressure: decode stalled, two responses fill the buffer
        gnt_en = 1; resp_en = 1; ready_en = 0;
        repeat (6) cycle();
        check("bp_head_pc", bus.instr_pc, 32'h0);
        check("bp_head_instr", bus.instr, 32'hFFFF0000);
        check("bp_pc_value", pc_value, 32'h8);
        repeat (4) begin
            cycle();
            check("bp_req_idle", bus.imem_req, 0);
            check("bp_pc_en_idle", pc_en, 0);
        end
        ready_en = 1;
        for (int i = 0; i < 10 && !bus.imem_req; i++) cycle();
        check("resume_req", bus.imem_req, 1);
        check("resume_addr", bus.imem_addr, 32'h8);

        // Streaming until 0xC has been granted
        for (int i = 0; i < 40 && pc_value != 32'h10; i++) cycle();
        check("stream_pc_reached", pc_value, 32'h10);

        // Grant stall at 0x10
        gnt_en = 0;
        for (int i = 0; i < 10 && !bus.imem_req; i++) cycle();
        repeat (3) begin
            cycle();
            check("stall_req_held", bus.imem_req, 1);
            check("stall_addr", bus.imem_addr, 32'h10);
            check("stall_pc_en", pc_en, 0);
        end
        gnt_en = 1;
        cycle();
        check("stall_granted", pc_value, 32'h14);

        check("pop_count", pop_pc.size(), 4);
        check("pop0_pc", pop_pc[0], 32'h0);
        check("pop1_pc", pop_pc[1], 32'h4);
        check("pop2_pc", pop_pc[2], 32'h8);
        check("pop3_pc", pop_pc[3], 32'hC);
        check("pop1_instr", pop_ins[1], 32'hFFFB0004);
        check("pop3_instr", pop_ins[3], 32'hFFF3000C);
        check("bp_back_to_back", pop_cyc[1] - pop_cyc[0], 1);

        // Flush while 0x14 is outstanding and 0x10 is buffered
        ready_en = 0;
        for (int i = 0; i < 10 && !(outst && outst_addr == 32'h14); i++) cycle();
        resp_en = 0;
        check("fl_pre_valid", bus.instr_valid, 1);
        check("fl_pre_pc", bus.instr_pc, 32'h10);
        flush_req = 1; flush_target = 32'h100;
        cycle();
        check("fl_valid_cleared", bus.instr_valid, 0);
        check("fl_pc_loaded", pc_value, 32'h100);
        force_en = 1; force_data = 32'hDEADBEEF; resp_en = 1; ready_en = 1;
        cycle();
        force_en = 0;
        check("fl_late_discarded", bus.instr_valid, 0);
        for (int i = 0; i < 10 && !bus.imem_req; i++) cycle();
        check("fl_next_req", bus.imem_req, 1);
        check("fl_next_addr", bus.imem_addr, 32'h100);
        for (int i = 0; i < 20 && pop_pc.size() < 5; i++) cycle();
        check("fl_pop_pc", pop_pc[4], 32'h100);
        check("fl_pop_instr", pop_ins[4], 32'hFEFF0100);

`ifdef IFU_MISALIGN_CHECK_EN
        flush_req = 1; flush_target = 32'h102;
        cycle();
        repeat (6) cycle();
        check("mis_req", bus.imem_req, 0);
        check("mis_fault", fetch_fault, 1);
        flush_req = 1; flush_target = 32'h200;
        cycle();
        check("mis_fault_clr", fetch_fault, 0);
        for (int i = 0; i < 5 && !bus.imem_req; i++) cycle();
        check("mis_req_resume", bus.imem_req, 1);
        check("mis_addr", bus.imem_addr, 32'h200);
`endif

        repeat (3) cycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout got running expected finished");
        $fatal(1);
    end

endmodule
